add16_nibble_seq: RTL and testbench

ADD16_NIBBLE_SEQ -- requirements
Module: add16_nibble_seq

---
 rtl/add16_nibble_seq.sv | 140 ++++++++++++++
 tb/tb_add16_nibble_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/add16_nibble_seq.sv
// add16_nibble_seq: 16-bit add/subtract built from one 4-bit adder reused
// over four cycles, least significant nibble first.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, sub, a, b  - operation request, 0 = a+b / 1 = a-b, operands
//   busy, done        - operation in progress, one-cycle completion pulse
//   result, cout      - sum/difference, carry out of bit 15 (sub: 1 = no borrow)
//   ovf, zero         - signed overflow, result == 0

// 4-bit ripple slice with carry in and carry out.
module adder_4_bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module add16_nibble_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        ovf,
    output logic        zero
);
    localparam int unsigned W  = 16;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;      // already inverted for subtraction
    logic [W-1:0]    work_q;
    logic            carry_q;
    logic [1:0]      idx_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            ovf_q;
    logic            zero_q;

    logic [NW-1:0]   nib_a;
    logic [NW-1:0]   nib_b;
    logic [NW-1:0]   add_sum;
    logic            add_cout;
    logic [W-1:0]    res_full;
    logic [3:0]      bit_off;

    // Select the current operand nibbles.
    assign bit_off = {idx_q, 2'b00};
    assign nib_a   = NW'(a_q >> bit_off);
    assign nib_b   = NW'(b_q >> bit_off);

    adder_4_bits u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Complete value once the top nibble is being summed.
    assign res_full = {add_sum, work_q[11:0]};

    // Sequencer, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {W{sub}};
                        carry_q <= sub;   // +1 completes the two's complement
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q[bit_off +: NW] <= add_sum;
                    carry_q               <= add_cout;
                    idx_q                 <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        result_q <= res_full;
                        cout_q   <= add_cout;
                        ovf_q    <= (a_q[W-1] == b_q[W-1]) && (res_full[W-1] != a_q[W-1]);
                        zero_q   <= (res_full == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_add16_nibble_seq.sv
// Self-checking bench for add16_nibble_seq: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_add16_nibble_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_err  = 0;
    int n_chk  = 0;
    int n_done = 0;
    int n_ops  = 0;

    // Expected held output values (last completed operation).
    logic [15:0] e_res  = 16'h0;
    logic        e_cout = 1'b0;
    logic        e_ovf  = 1'b0;
    logic        e_zero = 1'b0;

    add16_nibble_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain arithmetic reference for one operation.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                         output logic [15:0] r, output logic c, output logic v, output logic z);
        logic [16:0] u;
        int sx, sy, sr;
        u  = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r  = u[15:0];
        c  = s ? (x >= y) : u[16];
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = s ? (sx - sy) : (sx + sy);
        v  = (sr > 32767) || (sr < -32768);
        z  = (r == 16'h0);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_result"}, 32'(result), 32'(e_res));
        chk({tag, "_cout"},   32'(cout),   32'(e_cout));
        chk({tag, "_ovf"},    32'(ovf),    32'(e_ovf));
        chk({tag, "_zero"},   32'(zero),   32'(e_zero));
    endtask

    // Issue one operation in a cycle where start is accepted; returns in the
    // done cycle. mid=1 pulses an extra start while busy.
    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                         input bit mid);
        logic [15:0] r;
        logic c, v, z;
        model(oa, ob, os, r, c, v, z);
        a = oa; b = ob; sub = os; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk_held("hold");
            if (k == 1 && mid) begin
                start = 1'b1;
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        e_res = r; e_cout = c; e_ovf = v; e_zero = z;
        chk_held("op");
        n_ops++;
    endtask

    task automatic idle_cycle();
        tick();
        chk("done_idle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF;
        corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_held("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic add, accepted on the first edge after reset.
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("r031_result", 32'(result), 32'h5555);
        idle_cycle();
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("r032_zero", 32'(zero), 32'd1);
        chk("r032_cout", 32'(cout), 32'd1);
        idle_cycle();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("r033a_ovf", 32'(ovf), 32'd1);
        idle_cycle();
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("r033b_result", 32'(result), 32'h7FFF);
        chk("r033b_ovf", 32'(ovf), 32'd1);
        idle_cycle();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        chk("r034_result", 32'(result), 32'hFFFE);
        chk("r034_cout", 32'(cout), 32'd0);
        idle_cycle();

        // Start while busy is ignored, then back-to-back start in DONE.
        do_op(16'h2222, 16'h1111, 1'b0, 1'b1);
        chk("r035_first", 32'(result), 32'h3333);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        chk("r035_second", 32'(result), 32'h0002);
        idle_cycle();

        // Reset while at nibble index 2 aborts without a done pulse.
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        e_res = 16'h0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
        chk("r036_busy", 32'(busy), 32'd0);
        chk("r036_done", 32'(done), 32'd0);
        chk_held("r036_rst");
        tick();
        tick();
        chk("r036_done_held", 32'(done), 32'd0);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        chk("r036_result", 32'(result), 32'h0100);
        idle_cycle();

        // Randomized operations with random spacing and mid-flight starts.
        for (int i = 0; i < 40; i++) begin
            do_op(pick(), pick(), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        chk("done_count", 32'(n_done), 32'(n_ops));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
